// File: rtl/sc_operand_fetch_if.sv
// ============================================================================
//  Module      : sc_operand_fetch_if
//  Description : Operand-fetch bus bundle: source selects, shared buses, enables, ALU handshake.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface sc_operand_fetch_if #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int NUM_SOURCES   = 8,
    parameter int SEL_WIDTH     = 3
);
    logic                     SC_OperandFetch_Start_InHigh;
    logic [SEL_WIDTH-1:0]     SC_OperandFetch_SelA_In;
    logic [SEL_WIDTH-1:0]     SC_OperandFetch_SelB_In;
    logic [DATAWIDTH_BUS-1:0] SC_OperandFetch_DataBUS_A_In;
    logic [DATAWIDTH_BUS-1:0] SC_OperandFetch_DataBUS_B_In;
    logic                     SC_OperandFetch_Ack_InHigh;
    logic [NUM_SOURCES-1:0]   SC_OperandFetch_EnableBUS_A_Out;
    logic [NUM_SOURCES-1:0]   SC_OperandFetch_EnableBUS_B_Out;
    logic [DATAWIDTH_BUS-1:0] SC_OperandFetch_OperandA_Out;
    logic [DATAWIDTH_BUS-1:0] SC_OperandFetch_OperandB_Out;
    logic                     SC_OperandFetch_Valid_OutHigh;
    logic                     SC_OperandFetch_Error_OutHigh;
    logic                     SC_OperandFetch_Busy_OutHigh;

    // The fetch unit initiates bus transfers, so it takes the master side.
    modport master (
        input  SC_OperandFetch_Start_InHigh,
        input  SC_OperandFetch_SelA_In,
        input  SC_OperandFetch_SelB_In,
        input  SC_OperandFetch_DataBUS_A_In,
        input  SC_OperandFetch_DataBUS_B_In,
        input  SC_OperandFetch_Ack_InHigh,
        output SC_OperandFetch_EnableBUS_A_Out,
        output SC_OperandFetch_EnableBUS_B_Out,
        output SC_OperandFetch_OperandA_Out,
        output SC_OperandFetch_OperandB_Out,
        output SC_OperandFetch_Valid_OutHigh,
        output SC_OperandFetch_Error_OutHigh,
        output SC_OperandFetch_Busy_OutHigh
    );

    modport slave (
        output SC_OperandFetch_Start_InHigh,
        output SC_OperandFetch_SelA_In,
        output SC_OperandFetch_SelB_In,
        output SC_OperandFetch_DataBUS_A_In,
        output SC_OperandFetch_DataBUS_B_In,
        output SC_OperandFetch_Ack_InHigh,
        input  SC_OperandFetch_EnableBUS_A_Out,
        input  SC_OperandFetch_EnableBUS_B_Out,
        input  SC_OperandFetch_OperandA_Out,
        input  SC_OperandFetch_OperandB_Out,
        input  SC_OperandFetch_Valid_OutHigh,
        input  SC_OperandFetch_Error_OutHigh,
        input  SC_OperandFetch_Busy_OutHigh
    );
endinterface

`default_nettype wire

// File: rtl/sc_operand_fetch.sv
// ============================================================================
//  Module      : sc_operand_fetch
//  Description : Drives one-hot bus enables, samples Bus A/B and hands a registered
//                operand pair to the ALU over a valid/ack handshake.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sc_operand_fetch #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int NUM_SOURCES   = 8,
    parameter int SEL_WIDTH     = 3
) (
    input  wire logic          SC_OperandFetch_CLOCK_50,
    input  wire logic          SC_OperandFetch_Reset_InHigh,
    sc_operand_fetch_if.master fetchBus
);

    localparam logic [1:0] c_STATE_IDLE    = 2'd0;
    localparam logic [1:0] c_STATE_DRIVE   = 2'd1;
    localparam logic [1:0] c_STATE_CAPTURE = 2'd2;
    localparam logic [1:0] c_STATE_VALID   = 2'd3;

    logic [1:0]               r_state;
    logic [NUM_SOURCES-1:0]   r_enableA;
    logic [NUM_SOURCES-1:0]   r_enableB;
    logic [DATAWIDTH_BUS-1:0] r_operandA;
    logic [DATAWIDTH_BUS-1:0] r_operandB;
    logic                     r_valid;
    logic                     r_error;
    logic                     r_busy;

    logic [NUM_SOURCES-1:0]   w_decodeA;
    logic [NUM_SOURCES-1:0]   w_decodeB;

    // Out-of-range selects decode to an all-zero vector, so that bus is never driven.
    always_comb begin
        w_decodeA = '0;
        w_decodeB = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            w_decodeA[i] = (int'(fetchBus.SC_OperandFetch_SelA_In) == i);
            w_decodeB[i] = (int'(fetchBus.SC_OperandFetch_SelB_In) == i);
        end
    end

    always_ff @(negedge SC_OperandFetch_CLOCK_50 or posedge SC_OperandFetch_Reset_InHigh) begin
        if (SC_OperandFetch_Reset_InHigh) begin
            r_state    <= c_STATE_IDLE;
            r_enableA  <= '0;
            r_enableB  <= '0;
            r_operandA <= '0;
            r_operandB <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_STATE_IDLE: begin
                    if (fetchBus.SC_OperandFetch_Start_InHigh) begin
                        r_enableA <= w_decodeA;
                        r_enableB <= w_decodeB;
                        r_busy    <= 1'b1;
                        r_state   <= c_STATE_DRIVE;
                    end
                end
                c_STATE_DRIVE: begin
                    r_state <= c_STATE_CAPTURE;
                end
                c_STATE_CAPTURE: begin
                    // An empty enable vector marks an out-of-range select: that bus floats, so store 0.
                    r_operandA <= (|r_enableA) ? fetchBus.SC_OperandFetch_DataBUS_A_In : '0;
                    r_operandB <= (|r_enableB) ? fetchBus.SC_OperandFetch_DataBUS_B_In : '0;
                    r_error    <= ~(|r_enableA) | ~(|r_enableB);
                    r_enableA  <= '0;
                    r_enableB  <= '0;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= c_STATE_VALID;
                end
                c_STATE_VALID: begin
                    if (fetchBus.SC_OperandFetch_Ack_InHigh) begin
                        r_valid <= 1'b0;
                        r_error <= 1'b0;
                        if (fetchBus.SC_OperandFetch_Start_InHigh) begin
                            r_enableA <= w_decodeA;
                            r_enableB <= w_decodeB;
                            r_busy    <= 1'b1;
                            r_state   <= c_STATE_DRIVE;
                        end else begin
                            r_state <= c_STATE_IDLE;
                        end
                    end
                end
                default: begin
                    r_enableA <= '0;
                    r_enableB <= '0;
                    r_valid   <= 1'b0;
                    r_error   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= c_STATE_IDLE;
                end
            endcase
        end
    end

    assign fetchBus.SC_OperandFetch_EnableBUS_A_Out = r_enableA;
    assign fetchBus.SC_OperandFetch_EnableBUS_B_Out = r_enableB;
    assign fetchBus.SC_OperandFetch_OperandA_Out    = r_operandA;
    assign fetchBus.SC_OperandFetch_OperandB_Out    = r_operandB;
    assign fetchBus.SC_OperandFetch_Valid_OutHigh   = r_valid;
    assign fetchBus.SC_OperandFetch_Error_OutHigh   = r_error;
    assign fetchBus.SC_OperandFetch_Busy_OutHigh    = r_busy;

endmodule

`default_nettype wire
